// File: rtl/mem_if_pkg.sv
// mem_if_pkg
// Shared types and helpers for the single-port memory initiator.
//   size_e       : access size encoding (byte / half / word; 3 is illegal)
//   state_e      : initiator FSM states
//   wen_calc     : per-byte write enable from size and byte offset
//   load_extract : lane select plus sign/zero extension of a read word
package mem_if_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RSP  = 2'd2
  } state_e;

  function automatic logic [3:0] wen_calc(input logic [1:0] size,
                                          input logic [1:0] off);
    logic [3:0] w;
    case (size)
      SZ_B:    w = 4'b0001 << off;
      SZ_H:    w = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    w = 4'b1111;
      default: w = 4'b0000;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [31:0] sh;
    logic [31:0] r;
    case (size)
      SZ_B: begin
        sh = rdata >> {off, 3'b000};
        r  = {{24{~uns & sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        // Halfword lane is chosen by addr[1] only; addr[0] is known to be 0.
        sh = rdata >> {off[1], 4'b0000};
        r  = {{16{~uns & sh[15]}}, sh[15:0]};
      end
      default: begin
        sh = rdata;
        r  = rdata;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// mem_lane_steer
// Combinational store-path steering: byte enables and lane-replicated data.
//   active    : a legal store is being presented this cycle
//   size, off : access size and byte offset of the request
//   wdata     : right-aligned store data
//   mem_wen   : per-byte write enable (zero unless active)
//   mem_wdata : store data replicated across all lanes of its size
module mem_lane_steer
  import mem_if_pkg::*;
(
  input  logic        active,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata
);

  // Byte-enable generation, gated by the store qualifier.
  always_comb begin
    mem_wen = 4'b0000;
    if (active) begin
      mem_wen = wen_calc(size, off);
    end else begin
      mem_wen = 4'b0000;
    end
  end

  // Replicate store data so the enabled lanes see it regardless of offset.
  always_comb begin
    mem_wdata = wdata;
    case (size)
      SZ_B:    mem_wdata = {4{wdata[7:0]}};
      SZ_H:    mem_wdata = {2{wdata[15:0]}};
      default: mem_wdata = wdata;
    endcase
  end

endmodule

// File: rtl/mem_sp_initiator.sv
// mem_sp_initiator
// Converts byte-addressed load/store requests into accesses on a synchronous
// single-port 32-bit RAM with byte write enables, one access outstanding.
//   clk, rst                       : clock, async active-high reset
//   req_valid/req_ready            : request handshake (ready only in IDLE)
//   req_we, req_addr, req_size,
//   req_unsigned, req_wdata        : request fields
//   rsp_valid/rsp_ready            : response handshake
//   rsp_rdata, rsp_err             : load result / error flag
//   mem_addr, mem_wdata, mem_wen   : RAM address, write data, byte enables
//   mem_rdata                      : RAM read data (one cycle after address)
module mem_sp_initiator
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [1:0]            off_r;
  logic [1:0]            size_r;
  logic                  uns_r;
  logic                  rsp_valid_r;
  logic [31:0]           rsp_rdata_r;
  logic                  rsp_err_r;

  logic [31:0]           addr_hi_s;
  logic                  err_s;
  logic                  wr_active_s;

  // Request legality: size, natural alignment and address range.
  always_comb begin
    addr_hi_s = req_addr >> (ADDR_WIDTH + 2);
    err_s     = 1'b0;
    if (req_size == 2'd3) begin
      err_s = 1'b1;
    end else if ((req_size == SZ_H) && req_addr[0]) begin
      err_s = 1'b1;
    end else if ((req_size == SZ_W) && (req_addr[1:0] != 2'b00)) begin
      err_s = 1'b1;
    end else if (addr_hi_s != 32'd0) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Write strobes only for a legal store seen in IDLE; rst forces them low
  // so nothing is written while the block is held in reset.
  always_comb begin
    wr_active_s = 1'b0;
    if ((state_r == IDLE) && req_valid && req_we && !err_s && !rst) begin
      wr_active_s = 1'b1;
    end else begin
      wr_active_s = 1'b0;
    end
  end

  // Address is live from the request in IDLE so the RAM samples it on the
  // accept edge; afterwards it holds the captured word address.
  always_comb begin
    mem_addr = addr_r;
    if (state_r == IDLE) begin
      mem_addr = req_addr[ADDR_WIDTH+1:2];
    end else begin
      mem_addr = addr_r;
    end
  end

  mem_lane_steer u_lane_steer (
    .active    (wr_active_s),
    .size      (req_size),
    .off       (req_addr[1:0]),
    .wdata     (req_wdata),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata)
  );

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      off_r       <= 2'b00;
      size_r      <= 2'b00;
      uns_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            addr_r <= req_addr[ADDR_WIDTH+1:2];
            off_r  <= req_addr[1:0];
            size_r <= req_size;
            uns_r  <= req_unsigned;
            if (err_s || req_we) begin
              // Stores complete on the accept edge; errors never touch RAM.
              state_r     <= RSP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= err_s;
              rsp_rdata_r <= 32'd0;
            end else begin
              state_r <= RD;
            end
          end
        end
        RD: begin
          // RAM output now reflects the address sampled at accept.
          rsp_rdata_r <= load_extract(mem_rdata, off_r, size_r, uns_r);
          rsp_err_r   <= 1'b0;
          rsp_valid_r <= 1'b1;
          state_r     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= 32'd0;
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mem_sp_initiator.sv
// tb_mem_sp_initiator
// Self-checking bench: directed vector table, multi-cycle corner sequences
// (response stall, reset in RD and RSP) and randomized accesses checked
// against a byte-array reference model of memory.
module tb_mem_sp_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wen;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_sp_initiator #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wen      (mem_wen),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // 2048x32 synchronous single-port RAM with byte writes
  logic [31:0] ram [0:2047] = '{default: 32'd0};
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_wen[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: byte-addressed memory image
  logic [7:0] ref_mem [0:8191];

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic ref_err(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    if ((a % nbytes(s)) != 0) return 1'b1;
    if (a >= 32'd8192) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s,
                                           input logic uns);
    int n = nbytes(s);
    logic [63:0] v = 64'd0;
    logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_wen(input logic [31:0] a, input logic [1:0] s);
    int e = ((1 << nbytes(s)) - 1) << (a % 4);
    return e[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] w, input logic [1:0] s);
    int n = nbytes(s);
    if (n == 1) return {4{w[7:0]}};
    if (n == 2) return {2{w[15:0]}};
    return w;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] w);
    for (int i = 0; i < nbytes(s); i++) ref_mem[int'(a) + i] = w[8*i +: 8];
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // One complete access starting at a negedge with the DUT idle.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata, input int stall,
                           output logic err, output logic [31:0] rdata,
                           output logic [3:0] wen, output logic [31:0] wd, output int lat);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    #1;
    wen = mem_wen; wd = mem_wdata;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (rsp_valid !== 1'b1) lat = 99;
    err = rsp_err; rdata = rsp_rdata;
    repeat (stall) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_ready", {31'd0, rsp_valid}, 32'd0);
    check("req_ready_after_rsp", {31'd0, req_ready}, 32'd1);
  endtask

  // Access checked against the reference model, which it then updates.
  task automatic run_one(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, input int stall);
    logic e; logic [31:0] rd; logic [3:0] w; logic [31:0] wd; int lat;
    logic x_err;
    x_err = ref_err(addr, size);
    do_access(we, addr, size, uns, wdata, stall, e, rd, w, wd, lat);
    check("rnd_err", {31'd0, e}, {31'd0, x_err});
    check("rnd_lat", 32'(lat), (x_err || we) ? 32'd1 : 32'd2);
    check("rnd_rdata", rd, (!x_err && !we) ? ref_load(addr, size, uns) : 32'd0);
    check("rnd_wen", {28'd0, w}, (we && !x_err) ? {28'd0, ref_wen(addr, size)} : 32'd0);
    if (we && !x_err) begin
      check("rnd_wdata", wd, ref_wdata(wdata, size));
      ref_store(addr, size, wdata);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_wen;
    logic [31:0] exp_wdata;
    int          exp_lat;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic e; logic [31:0] rd; logic [3:0] w; logic [31:0] wd; int lat;
    logic [31:0] a; logic [1:0] s; logic we; int r;

    tbl[0]  = '{1'b1, 32'h10,   2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        4'hF,    32'hDEADBEEF, 1};
    tbl[1]  = '{1'b0, 32'h10,   2'd2, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 4'h0,    32'h0,        2};
    tbl[2]  = '{1'b0, 32'h13,   2'd0, 1'b0, 32'h0,        1'b0, 32'hFFFFFFDE, 4'h0,    32'h0,        2};
    tbl[3]  = '{1'b0, 32'h13,   2'd0, 1'b1, 32'h0,        1'b0, 32'h000000DE, 4'h0,    32'h0,        2};
    tbl[4]  = '{1'b1, 32'h22,   2'd1, 1'b0, 32'h1234,     1'b0, 32'h0,        4'b1100, 32'h12341234, 1};
    tbl[5]  = '{1'b0, 32'h20,   2'd2, 1'b0, 32'h0,        1'b0, 32'h12340000, 4'h0,    32'h0,        2};
    tbl[6]  = '{1'b0, 32'h2,    2'd2, 1'b0, 32'h0,        1'b1, 32'h0,        4'h0,    32'h0,        1};
    tbl[7]  = '{1'b1, 32'h2000, 2'd2, 1'b0, 32'hCAFEF00D, 1'b1, 32'h0,        4'h0,    32'h0,        1};
    tbl[8]  = '{1'b0, 32'h10,   2'd3, 1'b0, 32'h0,        1'b1, 32'h0,        4'h0,    32'h0,        1};
    tbl[9]  = '{1'b0, 32'h11,   2'd1, 1'b0, 32'h0,        1'b1, 32'h0,        4'h0,    32'h0,        1};
    tbl[10] = '{1'b0, 32'h12,   2'd1, 1'b0, 32'h0,        1'b0, 32'hFFFFDEAD, 4'h0,    32'h0,        2};
    tbl[11] = '{1'b0, 32'h10,   2'd1, 1'b1, 32'h0,        1'b0, 32'h0000BEEF, 4'h0,    32'h0,        2};
    tbl[12] = '{1'b1, 32'h21,   2'd0, 1'b0, 32'h000000A5, 1'b0, 32'h0,        4'b0010, 32'hA5A5A5A5, 1};
    tbl[13] = '{1'b0, 32'h20,   2'd2, 1'b0, 32'h0,        1'b0, 32'h1234A500, 4'h0,    32'h0,        2};
    tbl[14] = '{1'b0, 32'h1FFC, 2'd2, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0,    32'h0,        2};

    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'd0;

    // Reset: store request presented while held in reset must not write
    rst = 1'b1; rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'h11111111;
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_mem_wen", {28'd0, mem_wen}, 32'd0);
    req_valid = 1'b0; req_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      do_access(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, 0,
                e, rd, w, wd, lat);
      check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("vec%0d_wen", i), {28'd0, w}, {28'd0, tbl[i].exp_wen});
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      if (tbl[i].we && !tbl[i].exp_err)
        check($sformatf("vec%0d_wdata", i), wd, tbl[i].exp_wdata);
      if (tbl[i].we && !ref_err(tbl[i].addr, tbl[i].size))
        ref_store(tbl[i].addr, tbl[i].size, tbl[i].wdata);
    end

    // Response stall: outputs hold, new requests ignored
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
    for (int c = 0; c < 5; c++) begin
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("stall_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      check("stall_mem_wen", {28'd0, mem_wen}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0; req_we = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("stall_release_valid", {31'd0, rsp_valid}, 32'd0);
    check("stall_release_ready", {31'd0, req_ready}, 32'd1);

    // Reset while in RD discards the load
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_size = 2'd2;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    check("rd_state_not_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
    #1;
    check("rst_rd_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rd_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rd_mem_wen", {28'd0, mem_wen}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; rst = 1'b0;
    @(negedge clk);
    do_access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, e, rd, w, wd, lat);
    check("post_rst_load", rd, 32'hDEADBEEF);
    check("post_rst_lat", 32'(lat), 32'd2);

    // Reset in RSP after a store: response dropped, write kept
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_size = 2'd2; req_wdata = 32'h55AA55AA;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    check("rsp_state_valid", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_store(32'h30, 2'd2, 32'h55AA55AA);
    @(negedge clk);
    run_one(1'b0, 32'h30, 2'd2, 1'b0, 32'h0, 0);

    // Randomized accesses against the reference model
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom_range(0, 1));
      s  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r  = $urandom_range(0, 19);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h1F00 + 32'($urandom_range(0, 255));
      else if (r == 2) a = 32'h2000 + 32'($urandom_range(0, 255));
      else             a = 32'($urandom_range(0, 255));
      if (r >= 1 && r < 14) a = a & ~(32'(nbytes(s)) - 32'd1);
      run_one(we, a, s, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
